// File: rtl/delayed_combiner_pkg.sv
// Shared register map, operation modes and controller states for the delayed combiner.
package delayed_combiner_pkg;

    localparam logic [2:0] ADDR_A_FULL_N  = 3'd0;
    localparam logic [2:0] ADDR_B_FULL_N  = 3'd1;
    localparam logic [2:0] ADDR_Y_EMPTY_N = 3'd2;
    localparam logic [2:0] ADDR_Y_DATA    = 3'd3;
    localparam logic [2:0] ADDR_PUSH_A    = 3'd4;
    localparam logic [2:0] ADDR_PUSH_B    = 3'd5;
    localparam logic [2:0] ADDR_DELAY     = 3'd6;
    localparam logic [2:0] ADDR_CFG       = 3'd7;

    typedef enum logic [1:0] {
        MODE_OR  = 2'd0,
        MODE_AND = 2'd1,
        MODE_XOR = 2'd2,
        MODE_ADD = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/delayed_combiner_fifo.sv
// Synchronous FIFO; an enqueue into a full FIFO is accepted only when a dequeue happens on the same edge.
module combiner_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq,
    input  logic             deq,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             full_n,
    output logic             empty_n
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_enq_s;
    logic             do_deq_s;

    assign full_n   = (count_r != CW'(DEPTH));
    assign empty_n  = (count_r != CW'(0));
    assign do_deq_s = deq & empty_n;
    assign do_enq_s = enq & (full_n | do_deq_s);
    assign d_out    = mem_r[rd_ptr_r];

    // Pointer and occupancy tracking; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_enq_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_deq_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_enq_s, do_deq_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (do_enq_s) begin
            mem_r[wr_ptr_r] <= d_in;
        end
    end

endmodule

// File: rtl/delayed_combiner.sv
// Register-mapped two-operand combiner: operands queue in FIFOs A/B, a timer delays each
// combination, and results queue in FIFO Y for software to drain.
module delayed_combiner
    import delayed_combiner_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 4,
    parameter int DELAY_W       = 8,
    parameter int DEFAULT_DELAY = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       write_address,
    input  logic [WIDTH-1:0] write_data,
    input  logic             write_en,
    output logic             write_rdy,
    input  logic [2:0]       read_address,
    input  logic             read_en,
    output logic [WIDTH-1:0] read_data,
    output logic             read_rdy
);

    function automatic logic [WIDTH-1:0] combine(input mode_e m,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (m)
            MODE_OR:  combine = a | b;
            MODE_AND: combine = a & b;
            MODE_XOR: combine = a ^ b;
            MODE_ADD: combine = a + b;
            default:  combine = a | b;
        endcase
    endfunction

    logic [DELAY_W-1:0] delay_r;
    mode_e              mode_r;
    logic               ovf_r;
    logic               unf_r;
    state_e             state_r;
    state_e             state_nx_s;
    logic [DELAY_W-1:0] cnt_r;
    logic [DELAY_W-1:0] cnt_nx_s;
    logic [DELAY_W-1:0] dly_r;
    logic [DELAY_W-1:0] dly_nx_s;
    mode_e              op_r;
    mode_e              op_nx_s;
    logic               fire_s;

    logic               push_a_s;
    logic               push_b_s;
    logic               pop_y_s;
    logic               cfg_wr_s;
    logic               ready_s;
    logic               ovf_set_s;
    logic               unf_set_s;
    logic               flag_clr_s;
    mode_e              fire_mode_s;
    logic [WIDTH-1:0]   y_din_s;

    logic [WIDTH-1:0]   a_dout_s;
    logic [WIDTH-1:0]   b_dout_s;
    logic [WIDTH-1:0]   y_dout_s;
    logic               a_full_n_s;
    logic               a_empty_n_s;
    logic               b_full_n_s;
    logic               b_empty_n_s;
    logic               y_full_n_s;
    logic               y_empty_n_s;

    assign write_rdy  = 1'b1;
    assign read_rdy   = 1'b1;

    assign push_a_s   = write_en && (write_address == ADDR_PUSH_A);
    assign push_b_s   = write_en && (write_address == ADDR_PUSH_B);
    assign cfg_wr_s   = write_en && (write_address == ADDR_CFG);
    assign pop_y_s    = read_en && (read_address == ADDR_Y_DATA);
    assign ready_s    = a_empty_n_s & b_empty_n_s;

    // A push is only lost when the FIFO is full and not being drained on the same edge.
    assign ovf_set_s  = ((push_a_s & ~a_full_n_s) | (push_b_s & ~b_full_n_s)) & ~fire_s;
    assign unf_set_s  = pop_y_s & ~y_empty_n_s;
    assign flag_clr_s = cfg_wr_s & write_data[2];

    // A zero-delay fire from IDLE uses the live mode; the latched copy only exists from WAIT on.
    assign fire_mode_s = (state_r == ST_IDLE) ? mode_r : op_r;
    assign y_din_s     = combine(fire_mode_s, a_dout_s, b_dout_s);

    combiner_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .enq     (push_a_s),
        .deq     (fire_s),
        .d_in    (write_data),
        .d_out   (a_dout_s),
        .full_n  (a_full_n_s),
        .empty_n (a_empty_n_s)
    );

    combiner_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .enq     (push_b_s),
        .deq     (fire_s),
        .d_in    (write_data),
        .d_out   (b_dout_s),
        .full_n  (b_full_n_s),
        .empty_n (b_empty_n_s)
    );

    combiner_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .enq     (fire_s),
        .deq     (pop_y_s),
        .d_in    (y_din_s),
        .d_out   (y_dout_s),
        .full_n  (y_full_n_s),
        .empty_n (y_empty_n_s)
    );

    // Software-visible configuration and sticky error flags; a set beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_r <= DELAY_W'(DEFAULT_DELAY);
            mode_r  <= MODE_OR;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            if (write_en && (write_address == ADDR_DELAY)) begin
                delay_r <= write_data[DELAY_W-1:0];
            end
            if (cfg_wr_s) begin
                mode_r <= mode_e'(write_data[1:0]);
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (flag_clr_s) begin
                ovf_r <= 1'b0;
            end
            if (unf_set_s) begin
                unf_r <= 1'b1;
            end else if (flag_clr_s) begin
                unf_r <= 1'b0;
            end
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= DELAY_W'(0);
            dly_r   <= DELAY_W'(0);
            op_r    <= MODE_OR;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            dly_r   <= dly_nx_s;
            op_r    <= op_nx_s;
        end
    end

    // Next-state logic: latch delay/mode at transaction start, count, fire when Y has room.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        dly_nx_s   = dly_r;
        op_nx_s    = op_r;
        fire_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ready_s) begin
                    dly_nx_s = delay_r;
                    op_nx_s  = mode_r;
                    if ((delay_r == DELAY_W'(0)) && y_full_n_s) begin
                        fire_s = 1'b1;
                    end else begin
                        cnt_nx_s   = DELAY_W'(1);
                        state_nx_s = ST_WAIT;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if ((cnt_r >= dly_r) && y_full_n_s) begin
                    fire_s     = 1'b1;
                    state_nx_s = ST_IDLE;
                end else if (cnt_r >= dly_r) begin
                    cnt_nx_s = dly_r;
                end else begin
                    cnt_nx_s = cnt_r + DELAY_W'(1);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Read mux; all fields are zero-extended to the data-port width.
    always_comb begin
        read_data = {WIDTH{1'b0}};
        case (read_address)
            ADDR_A_FULL_N:  read_data = WIDTH'(a_full_n_s);
            ADDR_B_FULL_N:  read_data = WIDTH'(b_full_n_s);
            ADDR_Y_EMPTY_N: read_data = WIDTH'(y_empty_n_s);
            ADDR_Y_DATA:    read_data = y_empty_n_s ? y_dout_s : {WIDTH{1'b0}};
            ADDR_DELAY:     read_data = WIDTH'(delay_r);
            ADDR_CFG:       read_data = WIDTH'({ovf_r, unf_r, mode_r});
            default:        read_data = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: tb/tb_delayed_combiner.sv
// Directed scoreboard bench for delayed_combiner: expected Y values are queued at
// operand write time and compared as software drains Y.
module tb_delayed_combiner;
    import delayed_combiner_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       write_address = 3'd0;
    logic [WIDTH-1:0] write_data = 8'd0;
    logic             write_en = 1'b0;
    logic             write_rdy;
    logic [2:0]       read_address = 3'd0;
    logic             read_en = 1'b0;
    logic [WIDTH-1:0] read_data;
    logic             read_rdy;

    int checks = 0;
    int failures = 0;
    logic [WIDTH-1:0] sb [$];

    delayed_combiner #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY_W(8), .DEFAULT_DELAY(50)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [WIDTH-1:0] d);
        write_address = a;
        write_data    = d;
        write_en      = 1'b1;
        step();
        write_en      = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [WIDTH-1:0] exp);
        read_address = a;
        #1;
        check(tag, 32'(read_data), 32'(exp));
    endtask

    task automatic pop_check(input string tag);
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] e;
        read_address = ADDR_Y_DATA;
        #1;
        v = read_data;
        read_en = 1'b1;
        step();
        read_en = 1'b0;
        if (sb.size() == 0) begin
            e = {WIDTH{1'bx}};
        end else begin
            e = sb.pop_front();
        end
        check(tag, 32'(v), 32'(e));
    endtask

    initial begin
        int n;
        int seen;

        // 1: reset values
        #25 rst_n = 1'b1;
        step();
        rd_check("rst_a_full_n", ADDR_A_FULL_N, 8'd1);
        rd_check("rst_b_full_n", ADDR_B_FULL_N, 8'd1);
        rd_check("rst_y_empty_n", ADDR_Y_EMPTY_N, 8'd0);
        rd_check("rst_delay", ADDR_DELAY, 8'd50);
        rd_check("rst_cfg", ADDR_CFG, 8'd0);
        check("rst_rdy", {30'd0, write_rdy, read_rdy}, 32'd3);

        // 2: XOR with delay 3, Y visible exactly 4 edges after the B write
        wr(ADDR_DELAY, 8'd3);
        wr(ADDR_CFG, 8'd2);
        wr(ADDR_PUSH_A, 8'hA5);
        sb.push_back(8'hAA);
        wr(ADDR_PUSH_B, 8'h0F);
        for (int i = 1; i <= 4; i++) begin
            step();
            rd_check($sformatf("xor_lat_%0d", i), ADDR_Y_EMPTY_N, (i == 4) ? 8'd1 : 8'd0);
        end
        pop_check("xor_data");

        // 3: ADD with delay 0, carry dropped
        wr(ADDR_DELAY, 8'd0);
        wr(ADDR_CFG, 8'd3);
        wr(ADDR_PUSH_A, 8'hFF);
        sb.push_back(8'h01);
        wr(ADDR_PUSH_B, 8'h02);
        rd_check("add_not_yet", ADDR_Y_EMPTY_N, 8'd0);
        step();
        rd_check("add_lat", ADDR_Y_EMPTY_N, 8'd1);
        pop_check("add_data");

        // 4: fill Y, extra pair stalls in WAIT until a slot frees
        wr(ADDR_DELAY, 8'd2);
        wr(ADDR_CFG, 8'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            wr(ADDR_PUSH_A, 8'(i * 16));
            wr(ADDR_PUSH_B, 8'(i));
            sb.push_back(8'(i * 17));
            step(4);
        end
        wr(ADDR_PUSH_A, 8'h50);
        wr(ADDR_PUSH_B, 8'h05);
        sb.push_back(8'h55);
        step(10);
        check("stall_wait", 32'(dut.state_r), 32'(ST_WAIT));
        rd_check("stall_a_not_popped", ADDR_A_FULL_N, 8'd1);
        pop_check("stall_pop0");
        check("stall_still_wait", 32'(dut.state_r), 32'(ST_WAIT));
        step();
        check("stall_fired", 32'(dut.state_r), 32'(ST_IDLE));
        for (int i = 1; i <= DEPTH; i++) begin
            pop_check($sformatf("stall_pop%0d", i));
        end
        rd_check("stall_y_drained", ADDR_Y_EMPTY_N, 8'd0);

        // 5: overflow, underflow, flag clear, A contents intact
        for (int i = 0; i <= DEPTH; i++) begin
            wr(ADDR_PUSH_A, 8'(8'h21 + i));
        end
        rd_check("ovf_a_full_n", ADDR_A_FULL_N, 8'd0);
        rd_check("ovf_flag", ADDR_CFG, 8'h08);
        read_address = ADDR_Y_DATA;
        read_en = 1'b1;
        #1;
        check("unf_data", 32'(read_data), 32'd0);
        step();
        read_en = 1'b0;
        rd_check("unf_flag", ADDR_CFG, 8'h0C);
        wr(ADDR_CFG, 8'h04);
        rd_check("flag_clear", ADDR_CFG, 8'h00);
        wr(ADDR_DELAY, 8'd0);
        for (int i = 0; i < DEPTH; i++) begin
            sb.push_back(8'(8'h21 + i));
            wr(ADDR_PUSH_B, 8'h00);
        end
        step(2);
        rd_check("intact_a_empty", ADDR_A_FULL_N, 8'd1);
        rd_check("intact_no_ovf", ADDR_CFG, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            pop_check($sformatf("intact_pop%0d", i));
        end

        // 6a: reset mid-WAIT discards everything
        wr(ADDR_DELAY, 8'd50);
        wr(ADDR_PUSH_A, 8'h11);
        wr(ADDR_PUSH_B, 8'h22);
        step(20);
        check("midrst_wait", 32'(dut.state_r), 32'(ST_WAIT));
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        sb.delete();
        step();
        rd_check("midrst_y_empty", ADDR_Y_EMPTY_N, 8'd0);
        rd_check("midrst_a_empty", ADDR_A_FULL_N, 8'd1);
        rd_check("midrst_delay", ADDR_DELAY, 8'd50);
        seen = 0;
        read_address = ADDR_Y_EMPTY_N;
        repeat (60) begin
            step();
            if (read_data[0]) seen++;
        end
        check("midrst_no_push", 32'(seen), 32'd0);

        // 6b: delay rewrite during WAIT only affects the next transaction
        wr(ADDR_PUSH_A, 8'h0C);
        sb.push_back(8'h3C);
        wr(ADDR_PUSH_B, 8'h30);
        step(4);
        n = 4;
        wr(ADDR_DELAY, 8'd10);
        n++;
        read_address = ADDR_Y_EMPTY_N;
        #1;
        while (!read_data[0] && n < 100) begin
            step();
            n++;
        end
        check("late_delay_latency", 32'(n), 32'd51);
        pop_check("late_delay_data");
        rd_check("late_delay_reg", ADDR_DELAY, 8'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
